// File: rtl/uart_cplx_word_rx.sv
// 8N1 UART receiver that rebuilds signed complex (Re, Im) samples from 2*NBYTES bytes, MSB byte first.
// Define UART_STOP_CHECK_EN to drop bytes with a bad stop bit and discard the partial sample.
module uart_cplx_word_rx #(
    parameter int T_1_BIT      = 9,
    parameter int T_HALF_1_BIT = 4,
    parameter int CNT_W        = 4,
    parameter int BIT_WIDTH    = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    output logic [BIT_WIDTH-1:0] Re_o,
    output logic [BIT_WIDTH-1:0] Im_o,
    output logic                 en_o,
    output logic [1:0]           state_o
);
    localparam int NBYTES = BIT_WIDTH / 8;
    localparam int NB2    = 2 * NBYTES;
    localparam int IDX_W  = (NB2 > 2) ? $clog2(NB2) : 1;
    localparam int ACC_W  = 2 * BIT_WIDTH - 8;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(T_HALF_1_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(T_1_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 rx_q;
    logic                 rx_prev_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_q;
    logic [7:0]           shift_q;
    logic [IDX_W-1:0]     byte_idx_q;
    logic [ACC_W-1:0]     acc_q;
    logic [2*BIT_WIDTH-1:0] acc_d;
    logic                 fall_edge;
    logic                 stop_ok;

    // acc_q keeps every byte but the last; the final byte completes the word in acc_d.
    assign acc_d     = {acc_q, shift_q};
    assign fall_edge = rx_prev_q & ~rx_q;
    assign state_o   = state_q;

`ifdef UART_STOP_CHECK_EN
    assign stop_ok = rx_q;
`else
    assign stop_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            rx_q       <= 1'b1;
            rx_prev_q  <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            acc_q      <= '0;
            Re_o       <= '0;
            Im_o       <= '0;
            en_o       <= 1'b0;
        end else begin
            sync1_q   <= data_in;
            rx_q      <= sync1_q;
            rx_prev_q <= rx_q;
            en_o      <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Edge, not level: a held-low line never restarts a frame.
                    if (fall_edge) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (stop_ok) begin
                            acc_q <= acc_d[ACC_W-1:0];
                            if (byte_idx_q == IDX_LAST) begin
                                byte_idx_q <= '0;
                                Re_o       <= acc_d[2*BIT_WIDTH-1:BIT_WIDTH];
                                Im_o       <= acc_d[BIT_WIDTH-1:0];
                                en_o       <= 1'b1;
                            end else begin
                                byte_idx_q <= byte_idx_q + 1'b1;
                            end
                        end else begin
                            byte_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cplx_word_rx.sv
// Directed bench for uart_cplx_word_rx: serial byte driver, en_o monitor, per-scenario checks.
module tb_uart_cplx_word_rx;
    localparam int T_BIT = 9;
    localparam int W     = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         data_in = 1'b1;
    logic [W-1:0] re_o;
    logic [W-1:0] im_o;
    logic         en_o;
    logic [1:0]   state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] re_q[$];
    logic [W-1:0] im_q[$];
    int           cyc_q[$];

    uart_cplx_word_rx #(
        .T_1_BIT(9), .T_HALF_1_BIT(4), .CNT_W(4), .BIT_WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .Re_o(re_o), .Im_o(im_o), .en_o(en_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (en_o) begin
            re_q.push_back(re_o);
            im_q.push_back(im_o);
            cyc_q.push_back(cyc);
        end
    end

    task automatic clear_mon();
        re_q.delete();
        im_q.delete();
        cyc_q.delete();
    endtask

    task automatic idle_bits(input int n);
        data_in = 1'b1;
        repeat (n * T_BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        data_in = 1'b0;
        repeat (T_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            data_in = b[i];
            repeat (T_BIT) @(negedge clk);
        end
        data_in = stop_bit;
        repeat (T_BIT) @(negedge clk);
        data_in = 1'b1;
    endtask

    task automatic send_sample(input logic [47:0] w);
        for (int i = 0; i < 6; i++) send_byte(w[47-8*i -: 8], 1'b1);
    endtask

    task automatic check_one(input string name, input logic [W-1:0] exp_re, input logic [W-1:0] exp_im);
        checks++;
        if (re_q.size() !== 1) begin
            errors++;
            $display("FAIL %s pulses: got %0d expected 1", name, re_q.size());
        end else begin
            checks++;
            if (re_q[0] !== exp_re) begin
                errors++;
                $display("FAIL %s Re_o: got %h expected %h", name, re_q[0], exp_re);
            end
            checks++;
            if (im_q[0] !== exp_im) begin
                errors++;
                $display("FAIL %s Im_o: got %h expected %h", name, im_q[0], exp_im);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (re_o !== 24'h0) begin errors++; $display("FAIL reset Re_o: got %h expected 0", re_o); end
        checks++;
        if (im_o !== 24'h0) begin errors++; $display("FAIL reset Im_o: got %h expected 0", im_o); end
        checks++;
        if (en_o !== 1'b0) begin errors++; $display("FAIL reset en_o: got %b expected 0", en_o); end
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL reset state: got %0d expected 0", state_o); end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_basic();
        clear_mon();
        send_sample(48'h123456_FEDCBA);
        idle_bits(2);
        check_one("basic", 24'h123456, 24'hFEDCBA);
        checks++;
        if ($signed(im_o) !== -24'sd74566) begin
            errors++;
            $display("FAIL basic signed Im_o: got %0d expected -74566", $signed(im_o));
        end
    endtask

    task automatic test_async_reset();
        data_in = 1'b0;
        repeat (T_BIT + 20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (re_o !== 24'h0) begin errors++; $display("FAIL async_reset Re_o: got %h expected 0", re_o); end
        checks++;
        if (im_o !== 24'h0) begin errors++; $display("FAIL async_reset Im_o: got %h expected 0", im_o); end
        checks++;
        if (en_o !== 1'b0) begin errors++; $display("FAIL async_reset en_o: got %b expected 0", en_o); end
        @(negedge clk);
        rst = 1'b0;
        idle_bits(3);
    endtask

    task automatic test_glitch();
        clear_mon();
        data_in = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(3);
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL glitch state: got %0d expected 0", state_o); end
        send_sample(48'h000001_000002);
        idle_bits(2);
        check_one("glitch", 24'h000001, 24'h000002);
    endtask

    task automatic test_reset_mid_sample();
        clear_mon();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle_bits(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_bits(1);
        send_sample(48'h7FFFFF_800000);
        idle_bits(2);
        check_one("reset_mid_sample", 24'h7FFFFF, 24'h800000);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_sample(48'h010203_040506);
        send_sample(48'hAABBCC_112233);
        idle_bits(2);
        checks++;
        if (re_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b pulses: got %0d expected 2", re_q.size());
        end else begin
            checks++;
            if (re_q[0] !== 24'h010203) begin errors++; $display("FAIL b2b Re_o[0]: got %h expected 010203", re_q[0]); end
            checks++;
            if (im_q[0] !== 24'h040506) begin errors++; $display("FAIL b2b Im_o[0]: got %h expected 040506", im_q[0]); end
            checks++;
            if (re_q[1] !== 24'hAABBCC) begin errors++; $display("FAIL b2b Re_o[1]: got %h expected aabbcc", re_q[1]); end
            checks++;
            if (im_q[1] !== 24'h112233) begin errors++; $display("FAIL b2b Im_o[1]: got %h expected 112233", im_q[1]); end
            checks++;
            if (cyc_q[1] - cyc_q[0] !== 60 * T_BIT) begin
                errors++;
                $display("FAIL b2b spacing: got %0d expected %0d", cyc_q[1] - cyc_q[0], 60 * T_BIT);
            end
        end
    endtask

    task automatic test_stop_bit();
        clear_mon();
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        idle_bits(1);
`ifdef UART_STOP_CHECK_EN
        send_sample(48'h0A0B0C_0D0E0F);
        idle_bits(2);
        check_one("stop_check", 24'h0A0B0C, 24'h0D0E0F);
`else
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        send_byte(8'h99, 1'b1);
        send_byte(8'hAA, 1'b1);
        idle_bits(2);
        check_one("stop_ignored", 24'h556677, 24'h8899AA);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_glitch();
        test_reset_mid_sample();
        test_back_to_back();
        test_stop_bit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
